trigsnd_arb: RTL and testbench

- Round-robin arbiter and serialiser that shares one serial trigger line among NREQ token requesters.
- Grants one requester at a time and latches its token.
- Transmits the token as a framed serial word at clk/TOKEN_CLKDIV, in the exact format the channel-side serial trigger receiver decodes: start bit, token LSB first, parity, stop bit.
- Sits in fpga_main between the trigger/soft-trigger sources and the ser_trig fan-out to channel FPGAs.

---
 rtl/trigsnd_arb.sv | 146 ++++++++++++++
 tb/tb_trigsnd_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigsnd_arb.sv
// trigsnd_arb: round-robin arbiter that shares one serial trigger line among
// NREQ token requesters. A granted token is sent as a framed word, LSB first:
// start(1), token, odd parity, stop(0). Each bit lasts TOKEN_CLKDIV clocks,
// and every frame is followed by at least GAP_BITS idle bit periods.
module trigsnd_arb #(
  parameter int TOKEN_CLKDIV = 4,
  parameter int TOKEN_LENGTH = 10,
  parameter int NREQ         = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*TOKEN_LENGTH-1:0] tok_in,
  input  logic                         inhibit,
  output logic [NREQ-1:0]              ack,
  output logic [2:0]                   cur_src,
  output logic                         busy,
  output logic                         tok_sent,
  output logic                         ser_trig
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Frame is start + token + parity + stop; the start bit goes straight onto
  // the line, so the shift register only holds the remaining bits.
  localparam int FW = TOKEN_LENGTH + 3;

  logic [1:0]                             state;
  logic [2:0]                             ptr;
  logic [3:0]                             div;
  logic [3:0]                             bit_cnt;
  logic [7:0]                             gap_cnt;
  logic [FW-2:0]                          sreg;

  logic [NREQ-1:0][TOKEN_LENGTH-1:0]      tok_arr;
  logic                                   gnt_vld;
  logic [2:0]                             gnt_idx;
  logic [NREQ-1:0]                        gnt_oh;
  logic [TOKEN_LENGTH-1:0]                gnt_tok;
  logic                                   hi_vld;
  logic [2:0]                             hi_idx;
  logic [2:0]                             lo_idx;

  assign tok_arr = tok_in;

  // Round robin: lowest set req above the pointer wins; otherwise wrap to the
  // lowest set req overall (which may be the pointer itself).
  always_comb begin
    hi_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    gnt_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        lo_idx  = 3'(i);
        if (i > int'(ptr)) begin
          hi_vld = 1'b1;
          hi_idx = 3'(i);
        end
      end
    end
    gnt_idx = hi_vld ? hi_idx : lo_idx;
  end

  // One-hot grant and token of the winning requester.
  always_comb begin
    gnt_oh  = '0;
    gnt_tok = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        gnt_oh[i] = 1'b1;
        gnt_tok   = tok_arr[i];
      end
    end
  end

  // Arbitration, bit timing, framing and inter-frame gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= 3'(NREQ - 1);
      cur_src  <= 3'(NREQ - 1);
      ack      <= '0;
      busy     <= 1'b0;
      tok_sent <= 1'b0;
      ser_trig <= 1'b0;
      div      <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      sreg     <= '0;
    end else begin
      ack      <= '0;
      tok_sent <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!inhibit && gnt_vld) begin
            ack      <= gnt_oh;
            cur_src  <= gnt_idx;
            ptr      <= gnt_idx;
            // Remaining bits after start: token, odd parity, stop(0) on top.
            sreg     <= {1'b0, ~^gnt_tok, gnt_tok};
            ser_trig <= 1'b1;
            busy     <= 1'b1;
            div      <= 4'(TOKEN_CLKDIV - 1);
            bit_cnt  <= 4'(FW - 1);
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (div != 4'd0) begin
            div <= div - 4'd1;
          end else if (bit_cnt == 4'd0) begin
            // Stop bit has just finished its last clock.
            tok_sent <= 1'b1;
            ser_trig <= 1'b0;
            gap_cnt  <= 8'(GAP_BITS * TOKEN_CLKDIV - 1);
            state    <= ST_GAP;
          end else begin
            ser_trig <= sreg[0];
            sreg     <= {1'b0, sreg[FW-2:1]};
            bit_cnt  <= bit_cnt - 4'd1;
            div      <= 4'(TOKEN_CLKDIV - 1);
          end
        end
        ST_GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy     <= 1'b0;
          ser_trig <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigsnd_arb.sv
// Bench for trigsnd_arb: a default-parameter instance (A) and a slow, short
// token instance (B). A receiver model decodes ser_trig and checks frames
// against a queue of expected tokens; a grant monitor checks ack order.
module tb_trigsnd_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults
  logic [3:0]  req_a, ack_a;
  logic [39:0] tok_a;
  logic        inh_a, busy_a, sent_a, ser_a;
  logic [2:0]  cs_a;

  // Instance B: TOKEN_CLKDIV=16, TOKEN_LENGTH=4, GAP_BITS=3
  logic [3:0]  req_b, ack_b;
  logic [15:0] tok_b;
  logic        inh_b, busy_b, sent_b, ser_b;
  logic [2:0]  cs_b;

  trigsnd_arb u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .tok_in(tok_a), .inhibit(inh_a),
    .ack(ack_a), .cur_src(cs_a), .busy(busy_a), .tok_sent(sent_a), .ser_trig(ser_a)
  );

  trigsnd_arb #(.TOKEN_CLKDIV(16), .TOKEN_LENGTH(4), .NREQ(4), .GAP_BITS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .tok_in(tok_b), .inhibit(inh_b),
    .ack(ack_b), .cur_src(cs_b), .busy(busy_b), .tok_sent(sent_b), .ser_trig(ser_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [9:0] exp_tok_a[$], exp_tok_b[$];
  int         exp_gnt_a[$], exp_gnt_b[$];
  int         starts_a[$], starts_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial receiver model: mid-bit sampling, bit stability, tok_sent timing.
  task automatic rx_mon(input int which);
    int d, l, fw, phase;
    bit in_f;
    logic s, sp, ts, cur, stab, par, err;
    logic [15:0] bits;
    logic [9:0] tokv, expv;
    d = which ? 16 : 4;
    l = which ? 4 : 10;
    fw = l + 3;
    in_f = 0; sp = 0; phase = 0; cur = 0; stab = 1; bits = '0;
    forever begin
      @(negedge clk);
      s  = which ? ser_b : ser_a;
      ts = which ? sent_b : sent_a;
      if (!rst_n) begin
        in_f = 0;
        sp = 0;
        continue;
      end
      if (in_f) phase++;
      else if (s && !sp) begin
        in_f = 1; phase = 0; bits = '0; stab = 1; cur = s;
        if (which != 0) starts_b.push_back(cyc); else starts_a.push_back(cyc);
      end
      if (in_f && phase < fw * d) begin
        if (phase % d == 0) cur = s;
        else if (s !== cur) stab = 0;
        if (phase % d == d / 2) bits[phase / d] = s;
      end
      if (ts) begin
        if (!in_f) chk("tok_sent_spurious", 0, 1);
        else begin
          tokv = '0;
          for (int i = 0; i < l; i++) tokv[i] = bits[i + 1];
          par = bits[l + 1];
          err = (bits[0] !== 1'b1) || (bits[l + 2] !== 1'b0) || ((^tokv ^ par) !== 1'b1);
          chk("tok_sent_time", phase, fw * d);
          chk("rx_err", err, 0);
          chk("rx_bit_stable", stab, 1);
          if (which != 0 ? exp_tok_b.size() == 0 : exp_tok_a.size() == 0)
            chk("rx_unexpected", 0, 1);
          else begin
            expv = (which != 0) ? exp_tok_b.pop_front() : exp_tok_a.pop_front();
            chk("rx_token", tokv, expv);
            chk("rx_parity", par, ~^expv);
          end
          in_f = 0;
        end
      end else if (in_f && phase > fw * d) begin
        chk("tok_sent_missing", 0, 1);
        in_f = 0;
      end
      sp = s;
    end
  endtask

  // Grant monitor: one-hot ack, order against scoreboard, cur_src.
  task automatic ack_mon(input int which);
    logic [3:0] a;
    logic [2:0] cs;
    int idx, ones, e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      a  = which ? ack_b : ack_a;
      cs = which ? cs_b : cs_a;
      if (a != 4'd0) begin
        ones = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (a[i]) begin ones++; idx = i; end
        chk("ack_onehot", ones, 1);
        if (which != 0 ? exp_gnt_b.size() == 0 : exp_gnt_a.size() == 0)
          chk("ack_unexpected", 0, 1);
        else begin
          e = (which != 0) ? exp_gnt_b.pop_front() : exp_gnt_a.pop_front();
          chk("grant_order", idx, e);
          chk("cur_src", cs, e);
        end
      end
    end
  endtask

  task automatic wait_ack(input int which, input int bound, output int g);
    logic [3:0] a;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      a = which ? ack_b : ack_a;
      if (a != 4'd0) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (a[i]) g = i;
        return;
      end
    end
    chk("wait_ack_timeout", 0, 1);
    g = 0;
  endtask

  task automatic wait_idle(input int which, input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if ((which ? busy_b : busy_a) == 1'b0) return;
    end
    chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial rx_mon(0);
  initial rx_mon(1);
  initial ack_mon(0);
  initial ack_mon(1);

  initial begin
    int g, cnt;
    bit noack;
    rst_n = 1'b0;
    req_a = '0; tok_a = '0; inh_a = 1'b0;
    req_b = '0; tok_b = '0; inh_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ser", ser_a, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_tok_sent", sent_a, 0);
    chk("rst_cur_src", cs_a, 3);
    chk("rst_cur_src_b", cs_b, 3);
    rst_n = 1'b1;

    // Single request, token 0x155
    @(negedge clk);
    tok_a[9:0] = 10'h155; req_a[0] = 1'b1;
    exp_gnt_a.push_back(0); exp_tok_a.push_back(10'h155);
    wait_ack(0, 20, g);
    req_a[0] = 1'b0;
    chk("t1_busy", busy_a, 1);
    chk("t1_start_bit", ser_a, 1);
    wait_idle(0, 200);

    // Two simultaneous requests: order 0 then 2, start spacing 57
    rst_pulse();
    starts_a.delete();
    tok_a[9:0] = 10'h001; tok_a[29:20] = 10'h3FF; req_a = 4'b0101;
    exp_gnt_a.push_back(0); exp_gnt_a.push_back(2);
    exp_tok_a.push_back(10'h001); exp_tok_a.push_back(10'h3FF);
    wait_ack(0, 20, g);
    req_a[g] = 1'b0;
    wait_ack(0, 100, g);
    req_a[g] = 1'b0;
    wait_idle(0, 200);
    chk("t2_frames", starts_a.size(), 2);
    if (starts_a.size() == 2) chk("t2_start_spacing", starts_a[1] - starts_a[0], 57);

    // All four held; token of each requester bumped after its ack
    rst_pulse();
    for (int i = 0; i < 4; i++) tok_a[i*10 +: 10] = 10'h100 + 10'(i);
    req_a = 4'hF;
    exp_gnt_a.push_back(0); exp_gnt_a.push_back(1); exp_gnt_a.push_back(2);
    exp_gnt_a.push_back(3); exp_gnt_a.push_back(0); exp_gnt_a.push_back(1);
    exp_tok_a.push_back(10'h100); exp_tok_a.push_back(10'h101); exp_tok_a.push_back(10'h102);
    exp_tok_a.push_back(10'h103); exp_tok_a.push_back(10'h110); exp_tok_a.push_back(10'h111);
    for (int n = 0; n < 6; n++) begin
      wait_ack(0, 100, g);
      tok_a[g*10 +: 10] = tok_a[g*10 +: 10] + 10'h010;
      if (n == 5) req_a = '0;
    end
    wait_idle(0, 200);

    // Inhibit raised mid-frame, held 200 clocks
    tok_a[39:30] = 10'h2C3; req_a = 4'b1000;
    exp_gnt_a.push_back(3); exp_tok_a.push_back(10'h2C3);
    wait_ack(0, 20, g);
    req_a = '0;
    repeat (10) @(negedge clk);
    inh_a = 1'b1;
    tok_a[9:0] = 10'h0F0; req_a[0] = 1'b1;
    exp_gnt_a.push_back(0); exp_tok_a.push_back(10'h0F0);
    noack = 1;
    repeat (200) begin
      @(negedge clk);
      if (ack_a != 4'd0) noack = 0;
    end
    chk("inh_no_ack", noack, 1);
    inh_a = 1'b0;
    @(negedge clk);
    chk("inh_release_grant", ack_a, 4'b0001);
    req_a = '0;
    wait_idle(0, 200);

    // Reset 20 clocks into a frame
    tok_a[29:20] = 10'h0AB; req_a = 4'b0100;
    exp_gnt_a.push_back(2);
    wait_ack(0, 20, g);
    req_a = '0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ser", ser_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ack", ack_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tok_a[19:10] = 10'h2AA; req_a = 4'b0010;
    exp_gnt_a.push_back(1); exp_tok_a.push_back(10'h2AA);
    wait_ack(0, 20, g);
    req_a = '0;
    chk("midrst_cur_src", cs_a, 1);
    wait_idle(0, 200);

    // Instance B: 112-clock frame, 48-clock gap, next start 161 later
    starts_b.delete();
    tok_b[3:0] = 4'hA; tok_b[7:4] = 4'h5; req_b = 4'b0011;
    exp_gnt_b.push_back(0); exp_gnt_b.push_back(1);
    exp_tok_b.push_back(10'h00A); exp_tok_b.push_back(10'h005);
    wait_ack(1, 20, g);
    req_b[0] = 1'b0;
    cnt = 0;
    while (!sent_b && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("b_frame_len", cnt, 112);
    cnt = 0;
    while (busy_b && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("b_gap_len", cnt, 48);
    wait_ack(1, 20, g);
    req_b = '0;
    wait_idle(1, 400);
    chk("b_frames", starts_b.size(), 2);
    if (starts_b.size() == 2) chk("b_start_spacing", starts_b[1] - starts_b[0], 161);

    chk("scoreboard_tok_empty", exp_tok_a.size() + exp_tok_b.size(), 0);
    chk("scoreboard_gnt_empty", exp_gnt_a.size() + exp_gnt_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
